// File: rtl/mult_32_pkg.sv
// Shared types and constants for the 16x16 shift-and-add multiplier.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mult_32_pkg;

  // Operand, product and iteration sizing.
  localparam int OP_W   = 16;
  localparam int PROD_W = 32;
  localparam int ITER   = 16;
  localparam int CNT_W  = 5;

  // Counter preset loaded in LOAD; one RUN cycle consumes one multiplier bit.
  localparam logic [CNT_W-1:0] ITER_CNT = CNT_W'(ITER);

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Zero-extend a multiplicand into the product-width shift register.
  function automatic logic [PROD_W-1:0] zext_op(input logic [OP_W-1:0] a);
    return {{(PROD_W-OP_W){1'b0}}, a};
  endfunction

endpackage

// File: rtl/mult_32_ctrl.sv
// Sequencer for mult_32: IDLE/LOAD/RUN/DONE FSM plus the iteration counter.
// Latency: load one cycle after init is sampled, 16 shift cycles, done 17 cycles after init.
// Backpressure: none; init is only looked at in IDLE, ignored while busy.
module mult_32_ctrl
  import mult_32_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic init,
  output logic load,
  output logic shift,
  output logic done
);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;

  // State register; reset returns to IDLE from anywhere, aborting a running op.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; the RUN cycle that sees cnt==1 is the 16th and last iteration.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (init) state_nxt = LOAD;
      LOAD:    state_nxt = RUN;
      RUN:     if (cnt == CNT_W'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Iteration counter: preset in LOAD, decremented once per RUN cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (state == LOAD) begin
      cnt <= ITER_CNT;
    end else if (state == RUN) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Registered completion flag, high exactly for the cycle spent in DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done <= 1'b0;
    end else begin
      done <= (state == RUN) && (cnt == CNT_W'(1));
    end
  end

  // Datapath strobes are decoded straight from the state register.
  assign load  = (state == LOAD);
  assign shift = (state == RUN);

endmodule

// File: rtl/mult_32.sv
// Sequential unsigned 16x16 -> 32 shift-and-add multiplier.
// Latency: done rises 17 cycles after init is sampled in IDLE; 19-cycle back-to-back throughput.
// Backpressure: none; init is level-sampled in IDLE only, so a held init restarts on return to IDLE.
module mult_32
  import mult_32_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic [OP_W-1:0]   A,
  input  logic [OP_W-1:0]   B,
  output logic [PROD_W-1:0] pp,
  output logic              done
);

  logic              load;
  logic              shift;
  logic [PROD_W-1:0] mcand;
  logic [OP_W-1:0]   mplier;

  mult_32_ctrl u_ctrl (
    .clk   (clk),
    .rst   (rst),
    .init  (init),
    .load  (load),
    .shift (shift),
    .done  (done)
  );

  // Operand capture and shift-and-add; A/B are only sampled on load, so later
  // changes cannot disturb the running product. Sum of 16 partials fits in 32 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand  <= '0;
      mplier <= '0;
      pp     <= '0;
    end else if (load) begin
      mcand  <= zext_op(A);
      mplier <= B;
      pp     <= '0;
    end else if (shift) begin
      if (mplier[0]) begin
        pp <= pp + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: tb/tb_mult_32.sv
// Self-checking bench for mult_32 against a plain-arithmetic product model.
// Latency: checks the 17-cycle init-to-done latency and 19-cycle repeat period.
// Backpressure: n/a.
module tb_mult_32;

  logic        clk;
  logic        rst;
  logic        init;
  logic [15:0] A;
  logic [15:0] B;
  logic [31:0] pp;
  logic        done;

  int checks;
  int errors;

  mult_32 dut (
    .clk  (clk),
    .rst  (rst),
    .init (init),
    .A    (A),
    .B    (B),
    .pp   (pp),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the product as plain arithmetic.
  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] ea;
    logic [31:0] eb;
    ea = {16'h0, a};
    eb = {16'h0, b};
    return ea * eb;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One multiplication: init held for 'hold' cycles, optional operand change mid-RUN.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input int hold, input bit perturb);
    logic [31:0] exp;
    int          lat;
    exp = ref_mul(a, b);
    @(negedge clk);
    A    = a;
    B    = b;
    init = 1'b1;
    lat  = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == hold - 1) init = 1'b0;
      if (perturb && i == 3) begin
        A = 16'($urandom);
        B = 16'($urandom);
      end
      if (i == 1) check("pp_clear_at_load", pp, 32'h0);
      if (done) begin
        lat = i;
        break;
      end
    end
    check("latency", 32'(lat), 32'd17);
    check("product", pp, exp);
    @(negedge clk);
    check("done_width", {31'h0, done}, 32'h0);
    check("pp_hold_1", pp, exp);
    @(negedge clk);
    @(negedge clk);
    check("pp_hold_3", pp, exp);
    check("no_restart", {31'h0, done}, 32'h0);
  endtask

  initial begin
    logic [31:0] prev;
    logic [15:0] ra;
    logic [15:0] rb;
    int          gap;
    bit          seen;

    checks = 0;
    errors = 0;
    init   = 1'b0;
    A      = 16'h0;
    B      = 16'h0;
    rst    = 1'b1;
    #1 rst = 1'b0;

    // Reset held: init toggles must not start anything.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      init = ~init;
      A    = 16'h00F7;
      B    = 16'h007F;
      @(negedge clk);
      check("rst_pp", pp, 32'h0);
      check("rst_done", {31'h0, done}, 32'h0);
    end
    @(negedge clk);
    init = 1'b0;
    rst  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) check("idle_after_rst_done", {31'h0, done}, 32'h0);
    end
    check("idle_pp", pp, 32'h0);

    // Basic case, init high for 2 cycles.
    do_op(16'h00F7, 16'h007F, 2, 1'b0);
    check("basic_const", pp, 32'h00007A89);

    // Extremes.
    do_op(16'hFFFF, 16'hFFFF, 1, 1'b0);
    check("max_const", pp, 32'hFFFE0001);
    do_op(16'h0000, 16'hFFFF, 1, 1'b0);
    check("zero_const", pp, 32'h0);
    do_op(16'h1234, 16'h0001, 3, 1'b0);
    check("one_const", pp, 32'h00001234);

    // Operand change during RUN.
    do_op(16'hBEEF, 16'hCAFE, 1, 1'b1);
    do_op(16'hA5A5, 16'h8001, 1, 1'b1);

    // Random operands.
    for (int k = 0; k < 8; k++) begin
      do_op(16'($urandom), 16'($urandom), 1 + int'($urandom_range(0, 2)), k[0]);
    end

    // Held init: results every 19 cycles, pp cleared on each LOAD.
    ra = 16'($urandom);
    rb = 16'($urandom);
    @(negedge clk);
    A    = ra;
    B    = rb;
    init = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("held_first_done", {31'h0, seen}, 32'h1);
    prev = ref_mul(ra, rb);
    check("held_first_pp", pp, prev);
    for (int k = 0; k < 3; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      A  = ra;
      B  = rb;
      @(negedge clk);
      check("held_pp_after_done", pp, prev);
      @(negedge clk);
      check("held_pp_idle", pp, prev);
      @(negedge clk);
      check("held_pp_cleared", pp, 32'h0);
      gap = 3;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
        @(negedge clk);
        gap++;
        if (done) seen = 1'b1;
      end
      check("held_period", 32'(gap), 32'd19);
      prev = ref_mul(ra, rb);
      check("held_pp", pp, prev);
    end
    init = 1'b0;
    for (int i = 0; i < 25; i++) @(negedge clk);

    // Async reset mid-RUN: pp clears immediately, aborted op never signals done.
    @(negedge clk);
    A    = 16'h7777;
    B    = 16'hFFFF;
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    for (int i = 0; i < 8; i++) @(negedge clk);
    check("pre_rst_pp_nonzero", {31'h0, (pp != 32'h0)}, 32'h1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_pp", pp, 32'h0);
    check("mid_rst_done", {31'h0, done}, 32'h0);
    @(negedge clk);
    rst  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("aborted_no_done", {31'h0, seen}, 32'h0);
    check("aborted_pp", pp, 32'h0);
    do_op(16'h4321, 16'h00FF, 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
